// File: rtl/pixel_bank_writer.sv
// Pixel stream to 2x2-interleaved RAM bank writer.
// Raster-order beats are scattered over four banks by row/column parity.
module pixel_bank_writer #(
  parameter int RAM_AW = 13,
  parameter int QN     = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [QN-1:0]     s_data,
  output logic              s_ready,
  input  logic              ram_busy,
  output logic              wea1,
  output logic              wea2,
  output logic              wea3,
  output logic              wea4,
  output logic              ena1,
  output logic              ena2,
  output logic              ena3,
  output logic              ena4,
  output logic [RAM_AW-1:0] AA1,
  output logic [RAM_AW-1:0] AA2,
  output logic [RAM_AW-1:0] AA3,
  output logic [RAM_AW-1:0] AA4,
  output logic [QN-1:0]     DA1,
  output logic [QN-1:0]     DA2,
  output logic [QN-1:0]     DA3,
  output logic [QN-1:0]     DA4,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0]     COL_ONE  = CW'(1);
  localparam logic [RW-1:0]     ROW_ONE  = RW'(1);
  localparam logic [RAM_AW-1:0] ADDR_ONE = RAM_AW'(1);
  localparam logic [RAM_AW-1:0] HALF_W   = RAM_AW'(IMG_W / 2);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [RAM_AW-1:0]   base;
  logic [RAM_AW-1:0]   addr;
  logic [3:0]          wen;
  logic [RAM_AW-1:0]   aa [4];
  logic [QN-1:0]       da [4];
  logic                accept;
  logic [1:0]          bank;

  assign s_ready = (state == WRITE) & ~ram_busy;
  assign accept  = s_valid & s_ready;
  assign bank    = {row[0], col[0]};
  assign busy    = (state == WRITE);

  assign wea1 = wen[0];
  assign wea2 = wen[1];
  assign wea3 = wen[2];
  assign wea4 = wen[3];
  assign ena1 = wen[0];
  assign ena2 = wen[1];
  assign ena3 = wen[2];
  assign ena4 = wen[3];
  assign AA1  = aa[0];
  assign AA2  = aa[1];
  assign AA3  = aa[2];
  assign AA4  = aa[3];
  assign DA1  = da[0];
  assign DA2  = da[1];
  assign DA3  = da[2];
  assign DA4  = da[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
      base  <= '0;
      addr  <= '0;
      wen   <= '0;
      done  <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        aa[k] <= '0;
        da[k] <= '0;
      end
    end else begin
      wen  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= WRITE;
            col   <= '0;
            row   <= '0;
            base  <= '0;
            addr  <= '0;
          end
        end
        WRITE: begin
          if (accept) begin
            wen[bank] <= 1'b1;
            aa[bank]  <= addr;
            da[bank]  <= s_data;
            // addr tracks base + col/2; base moves only once per row pair
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + ROW_ONE;
              if (row[0]) begin
                base <= base + HALF_W;
                addr <= base + HALF_W;
              end else begin
                addr <= base;
              end
              if (row == ROW_LAST) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end else begin
              col <= col + COL_ONE;
              if (col[0]) addr <= addr + ADDR_ONE;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pixel_bank_writer.md
PIXEL_BANK_WRITER -- requirements
Module: pixel_bank_writer

Interface
REQ-001 Parameter RAM_AW, default 13: bank address width; each bank holds 2^RAM_AW words.
REQ-002 Parameter QN, default 8: pixel width in bits.
REQ-003 Parameter IMG_W, default 128: pixels per row; SHALL be even.
REQ-004 Parameter IMG_H, default 128: rows per frame; SHALL be even, with IMG_W*IMG_H/4 <= 2^RAM_AW.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
REQ-008 s_valid  in  1  pixel beat valid, raster order.
REQ-009 s_data  in  QN  pixel value.
REQ-010 s_ready  out  1  writer accepts the beat this cycle.
REQ-011 ram_busy  in  1  bank reset in progress (driven by the bank array's rsta_busy); stalls intake.
REQ-012 wea1..wea4  out  1 each  per-bank write enable.
REQ-013 ena1..ena4  out  1 each  per-bank port-A enable.
REQ-014 AA1..AA4  out  RAM_AW each  per-bank write address.
REQ-015 DA1..DA4  out  QN each  per-bank write data.
REQ-016 busy  out  1  high in WRITE state.
REQ-017 done  out  1  one-cycle pulse after the last pixel's bank write has been issued.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE and DONE.
REQ-019 IDLE with start=1 SHALL go to WRITE and clear row and column counters and the bank address; IDLE with start=0 SHALL stay in IDLE.
REQ-020 start SHALL be ignored in WRITE and DONE.
REQ-021 s_ready SHALL equal (state==WRITE) & ~ram_busy, combinationally; a beat is accepted when s_valid & s_ready.
REQ-022 s_valid asserted outside WRITE SHALL be ignored, and no write SHALL be issued.
REQ-023 The bank index SHALL be b = 2*row[0] + col[0], where b=0 selects bank 1 and b=3 selects bank 4 (2x2 interleave).
REQ-024 The word address SHALL be (row>>1)*(IMG_W/2) + (col>>1), RAM_AW bits.
REQ-025 The address SHALL be produced by incremental counters; no multiplier SHALL be used.
REQ-026 An accepted beat SHALL appear on the selected bank one cycle later: wea/ena=1, AA=address, DA=s_data.
REQ-027 In that cycle the wea and ena of the other banks SHALL be 0.
REQ-028 All AA and DA outputs SHALL hold their last values when not writing.
REQ-029 Without an accepted beat, every wea and ena SHALL be 0 in the following cycle.
REQ-030 The column counter SHALL wrap from IMG_W-1 to 0 and increment the row counter.
REQ-031 The address base SHALL advance by IMG_W/2 only on the wrap out of an odd row.
REQ-032 Acceptance of the beat at row=IMG_H-1, col=IMG_W-1 SHALL move WRITE to DONE, with s_ready low from the next cycle.
REQ-033 DONE SHALL last one cycle with done=1, coincident with the final bank write, then return to IDLE.
REQ-034 ram_busy rising mid-frame SHALL stall intake with counters held; intake SHALL resume at the same pixel position when ram_busy falls.
REQ-035 Back-to-back beats SHALL be sustained at one pixel per cycle.

Reset
REQ-036 While rst_n=0: state=IDLE, counters and address 0.
REQ-037 While rst_n=0: s_ready, busy and done = 0.
REQ-038 While rst_n=0: all wea and ena = 0, and all AA and DA = 0.
REQ-039 Reset asserted mid-frame SHALL abort the frame, and no further write SHALL be issued.
REQ-040 After reset is released, a new start SHALL be required before any beat is accepted.

Verification (IMG_W=4, IMG_H=4 unless stated)
REQ-041 Reset, then start, then 16 contiguous beats of values 0..15 -> bank 1 receives {0,2,8,10} at addresses 0,1,2,3; bank 2 receives {1,3,9,11}; bank 3 receives {4,6,12,14}; bank 4 receives {5,7,13,15}; done pulses in the cycle of the 16th write.
REQ-042 s_valid=1 held in IDLE for 5 cycles with no start -> s_ready=0 and no wea asserted.
REQ-043 ram_busy=1 for 3 cycles after beat 6 -> s_ready=0 for those 3 cycles, and beat 7 writes bank 4 at address 1.
REQ-044 start pulsed again during WRITE at beat 4 -> counters unaffected, and the frame completes normally.
REQ-045 rst_n=0 after beat 9 -> all outputs 0 immediately; after release, a new start followed by value 0x55 writes bank 1 at address 0.
REQ-046 With defaults (128x128), a full frame -> the last write goes to bank 4 at address 4095, and done pulses exactly once.
